riscv_fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 16 +
 rtl/riscv_fetch_stage_if.sv | 12 +
 rtl/riscv_fetch_stage_fd_pipe_reg.sv | 27 ++
 rtl/riscv_fetch_stage.sv | 128 ++++++++++++
 tb/tb_riscv_fetch_stage.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Types and constants shared by the RISC-V pipeline stages.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] instr;
      logic            valid;
   } fd_reg_t;

endpackage

// File: rtl/riscv_fetch_stage_if.sv
// Instruction-memory request/response channel; at most one request in flight.
interface riscv_fetch_stage_if #(
   parameter int DW = 32
);
   logic          req;
   logic [DW-1:0] addr;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (output req, addr, input rvalid, rdata);
   modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/riscv_fetch_stage_fd_pipe_reg.sv
// Pipeline register with priority reset > flush > stall > load; a bubble keeps the PC fields.
module fd_pipe_reg
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] BUBBLE = NOP_INSTR
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    load,
   input  logic    stall,
   input  logic    flush,
   input  fd_reg_t d,
   output fd_reg_t q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '{pc: '0, pc_plus4: '0, instr: BUBBLE, valid: 1'b0};
      end else if (flush || (!stall && !load)) begin
         q.instr <= BUBBLE;
         q.valid <= 1'b0;
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/riscv_fetch_stage.sv
// Fetch stage: owns the PC, talks to instruction memory and feeds the F/D register.
module riscv_fetch_stage #(
   parameter int            DW        = 32,
   parameter logic [DW-1:0] ADDENT    = 4,
   parameter logic [DW-1:0] RESET_PC  = '0,
   parameter logic [DW-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                stall_fd_i,
   input  logic                flush_fd_i,
   input  logic                br_taken_i,
   input  logic [DW-1:0]       br_target_i,
   riscv_fetch_stage_if.master imem,
   output logic [DW-1:0]       pc_d_o,
   output logic [DW-1:0]       instr_d_o,
   output logic [DW-1:0]       pc_plus4_d_o,
   output logic                valid_d_o
);
   import riscv_pkg::*;

   fetch_state_e  state_q, state_d;
   logic [DW-1:0] pc_q, pc_n, pc_inc, target;
   logic [DW-1:0] hold_q, hold_n;
   logic          kill_q, kill_n;
   logic          fd_load;
   logic          unused_tgt_lsb;
   fd_reg_t       fd_in, fd_q;

   assign target         = {br_target_i[DW-1:2], 2'b00};
   assign unused_tgt_lsb = ^br_target_i[1:0];
   assign pc_inc         = pc_q + ADDENT;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_n;
         kill_q  <= kill_n;
      end
   end

   always_ff @(posedge clk_i) hold_q <= hold_n;

   // pc_q always names the address of the request in flight (or about to be issued)
   always_comb begin
      state_d   = state_q;
      pc_n      = pc_q;
      kill_n    = kill_q;
      hold_n    = hold_q;
      imem.req  = 1'b0;
      imem.addr = pc_q;
      fd_load   = 1'b0;
      fd_in     = '{pc: pc_q, pc_plus4: pc_inc, instr: imem.rdata, valid: 1'b1};
      unique case (state_q)
         S_IDLE: begin
            if (br_taken_i) pc_n = target;
            state_d = S_REQ;
         end
         S_REQ: begin
            imem.req = 1'b1;
            if (br_taken_i) begin
               imem.addr = target;
               pc_n      = target;
            end
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem.rvalid) begin
               if (br_taken_i) begin
                  imem.req  = 1'b1;
                  imem.addr = target;
                  pc_n      = target;
                  kill_n    = 1'b0;
               end else if (kill_q) begin
                  imem.req = 1'b1;
                  kill_n   = 1'b0;
               end else if (!stall_fd_i) begin
                  fd_load   = 1'b1;
                  imem.req  = 1'b1;
                  imem.addr = pc_inc;
                  pc_n      = pc_inc;
               end else begin
                  hold_n  = imem.rdata;
                  state_d = S_HOLD;
               end
            end else if (br_taken_i) begin
               // response still owed for the old path; drop it when it lands
               pc_n   = target;
               kill_n = 1'b1;
            end
         end
         S_HOLD: begin
            fd_in.instr = hold_q;
            if (br_taken_i) begin
               pc_n    = target;
               state_d = S_REQ;
            end else if (!stall_fd_i) begin
               fd_load = 1'b1;
               pc_n    = pc_inc;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   fd_pipe_reg #(
      .BUBBLE (NOP_INSTR)
   ) u_fd_reg (
      .clk   (clk_i),
      .rst   (rst_i),
      .load  (fd_load),
      .stall (stall_fd_i),
      .flush (flush_fd_i | br_taken_i),
      .d     (fd_in),
      .q     (fd_q)
   );

   assign pc_d_o       = fd_q.pc;
   assign instr_d_o    = fd_q.instr;
   assign pc_plus4_d_o = fd_q.pc_plus4;
   assign valid_d_o    = fd_q.valid;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Scoreboard bench for riscv_fetch_stage with a variable-latency instruction memory model.
module tb_riscv_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        br = 1'b0;
   logic [31:0] br_tgt = '0;
   logic [31:0] pc_d, instr_d, pc_plus4_d;
   logic        valid_d;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   logic        edge_stall, edge_rst, is_new;
   exp_t        exp_q[$];

   riscv_fetch_stage_if #(.DW(32)) bus ();

   riscv_fetch_stage #(
      .DW(32), .ADDENT(32'd4), .RESET_PC(32'h0), .NOP_INSTR(NOP)
   ) dut (
      .clk_i(clk), .rst_i(rst), .stall_fd_i(stall), .flush_fd_i(flush),
      .br_taken_i(br), .br_target_i(br_tgt), .imem(bus),
      .pc_d_o(pc_d), .instr_d_o(instr_d), .pc_plus4_d_o(pc_plus4_d), .valid_d_o(valid_d)
   );

   always #5 clk = ~clk;

   // memory model: response arrives lat cycles after the request cycle
   int          lat = 1;
   int          cnt = 0;
   logic        pend = 1'b0;
   logic [31:0] paddr = '0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        inj = 1'b0;
   logic [31:0] inj_data = '0;

   assign bus.rvalid = mem_rvalid | inj;
   assign bus.rdata  = inj ? inj_data : mem_rdata;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0040_0193;
         32'h0000_0004: return 32'h0801_c463;
         32'h0000_0008: return 32'h0000_0033;
         default:       return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   always @(posedge clk) begin
      mem_rvalid <= 1'b0;
      if (rst) begin
         pend <= 1'b0;
      end else if (bus.req) begin
         if (lat <= 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= mem_word(bus.addr);
         end else begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            paddr <= bus.addr;
         end
      end else if (pend) begin
         if (cnt == 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= mem_word(paddr);
            pend       <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   task automatic tick();
      edge_stall = stall;
      edge_rst   = rst;
      @(posedge clk);
      #1;
      cyc++;
      is_new = valid_d && !edge_stall && !edge_rst;
   endtask

   task automatic push(input logic [31:0] pc);
      exp_q.push_back('{pc: pc, instr: mem_word(pc), pc4: pc + 32'd4});
   endtask

   task automatic do_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0; br = 1'b0; inj = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      lat = 1;
      rst = 1'b1; stall = 1'b0; flush = 1'b0; br = 1'b0;
      tick();
      tick();
      vectors++;
      if ({pc_d, instr_d, pc_plus4_d, valid_d} !== {32'h0, NOP, 32'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_d: got pc=%h instr=%h pc4=%h v=%b, want 0/%h/0/0", pc_d, instr_d, pc_plus4_d, valid_d, NOP);
      end
      vectors++;
      if (bus.req !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_req: got req=%b, want 0", bus.req);
      end
      push(32'h0); push(32'h4); push(32'h8);
      rst = 1'b0;
      tick();
      vectors++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin
         miscompares++;
         $display("FAIL first_req: got req=%b addr=%h, want 1/00000000", bus.req, bus.addr);
      end
      vectors++;
      if (valid_d !== 1'b0) begin
         miscompares++;
         $display("FAIL early_valid: got %b, want 0", valid_d);
      end
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         tick();
         if (is_new) begin
            vectors++;
            e = exp_q.pop_front();
            if ({pc_d, instr_d, pc_plus4_d} !== {e.pc, e.instr, e.pc4}) begin
               miscompares++;
               $display("FAIL reset_seq: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h", pc_d, instr_d, pc_plus4_d, e.pc, e.instr, e.pc4);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL reset_drain: %0d left, want 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_stall();
      exp_t e;
      logic got;
      int   req_seen;
      lat = 1;
      do_reset();
      push(32'h0); push(32'h4); push(32'h8);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         tick();
         if (is_new) begin
            got = 1'b1;
            vectors++;
            e = exp_q.pop_front();
            if ({pc_d, instr_d, pc_plus4_d} !== {e.pc, e.instr, e.pc4}) begin
               miscompares++;
               $display("FAIL stall_first: got pc=%h instr=%h, want pc=%h instr=%h", pc_d, instr_d, e.pc, e.instr);
            end
         end
      end
      stall    = 1'b1;
      req_seen = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         req_seen += int'(bus.req);
         vectors++;
         if ({pc_d, instr_d, pc_plus4_d, valid_d} !== {32'h0, 32'h0040_0193, 32'h4, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_hold: got pc=%h instr=%h pc4=%h v=%b, want 0/00400193/4/1", pc_d, instr_d, pc_plus4_d, valid_d);
         end
      end
      vectors++;
      if (req_seen != 0) begin
         miscompares++;
         $display("FAIL stall_req: got %0d requests while stalled, want 0", req_seen);
      end
      stall = 1'b0;
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         tick();
         if (is_new) begin
            vectors++;
            e = exp_q.pop_front();
            if ({pc_d, instr_d, pc_plus4_d} !== {e.pc, e.instr, e.pc4}) begin
               miscompares++;
               $display("FAIL stall_seq: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h", pc_d, instr_d, pc_plus4_d, e.pc, e.instr, e.pc4);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL stall_drain: %0d left, want 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_redirect();
      exp_t e;
      logic arm, fired, seen_req;
      lat = 3;
      do_reset();
      push(32'h0); push(32'h4); push(32'h8); push(32'h88); push(32'h8C);
      arm = 1'b0; fired = 1'b0; seen_req = 1'b0;
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
         tick();
         if (is_new) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL redir_seq: unexpected pc=%h instr=%h", pc_d, instr_d);
            end else begin
               e = exp_q.pop_front();
               if ({pc_d, instr_d, pc_plus4_d} !== {e.pc, e.instr, e.pc4}) begin
                  miscompares++;
                  $display("FAIL redir_seq: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h", pc_d, instr_d, pc_plus4_d, e.pc, e.instr, e.pc4);
               end
            end
         end
         if (br) begin
            br = 1'b0;
            vectors++;
            if (instr_d !== NOP || valid_d !== 1'b0) begin
               miscompares++;
               $display("FAIL redir_bubble: got instr=%h v=%b, want %h/0", instr_d, valid_d, NOP);
            end
         end else if (arm) begin
            br = 1'b1; br_tgt = 32'h88; arm = 1'b0; fired = 1'b1;
         end
         if (!fired && bus.req && bus.addr == 32'hC) arm = 1'b1;
         if (fired && !br && bus.req && !seen_req) begin
            seen_req = 1'b1;
            vectors++;
            if (bus.addr !== 32'h88) begin
               miscompares++;
               $display("FAIL redir_req: got addr=%h, want 00000088", bus.addr);
            end
         end
      end
      br = 1'b0;
      vectors++;
      if (exp_q.size() != 0 || !seen_req) begin
         miscompares++;
         $display("FAIL redir_drain: %0d left, req_seen=%b, want 0/1", exp_q.size(), seen_req);
      end
      exp_q.delete();
   endtask

   task automatic test_flush_stall();
      exp_t e;
      logic got;
      lat = 1;
      do_reset();
      push(32'h0); push(32'h4); push(32'h8);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         tick();
         if (is_new) begin
            got = 1'b1;
            vectors++;
            e = exp_q.pop_front();
            if ({pc_d, instr_d} !== {e.pc, e.instr}) begin
               miscompares++;
               $display("FAIL fs_first: got pc=%h instr=%h, want pc=%h instr=%h", pc_d, instr_d, e.pc, e.instr);
            end
         end
      end
      flush = 1'b1; stall = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0;
      vectors++;
      if (instr_d !== NOP || valid_d !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_stall: got instr=%h v=%b, want %h/0", instr_d, valid_d, NOP);
      end
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         tick();
         if (is_new) begin
            vectors++;
            e = exp_q.pop_front();
            if ({pc_d, instr_d, pc_plus4_d} !== {e.pc, e.instr, e.pc4}) begin
               miscompares++;
               $display("FAIL fs_seq: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h", pc_d, instr_d, pc_plus4_d, e.pc, e.instr, e.pc4);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL fs_drain: %0d left, want 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_latency();
      exp_t        e;
      int          last_cyc;
      logic        outstanding;
      logic [31:0] req_exp;
      lat = 3;
      do_reset();
      push(32'h0); push(32'h4); push(32'h8);
      last_cyc = -1; outstanding = 1'b0; req_exp = 32'h0;
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
         tick();
         if (bus.req) begin
            vectors++;
            if (bus.addr !== req_exp || (outstanding && !bus.rvalid)) begin
               miscompares++;
               $display("FAIL lat_req: got addr=%h outstanding=%b, want addr=%h outstanding=0", bus.addr, outstanding && !bus.rvalid, req_exp);
            end
            req_exp += 32'd4;
         end
         if (bus.rvalid) outstanding = 1'b0;
         if (bus.req) outstanding = 1'b1;
         if (is_new) begin
            vectors++;
            e = exp_q.pop_front();
            if ({pc_d, instr_d, pc_plus4_d} !== {e.pc, e.instr, e.pc4}) begin
               miscompares++;
               $display("FAIL lat_seq: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h", pc_d, instr_d, pc_plus4_d, e.pc, e.instr, e.pc4);
            end
            if (last_cyc >= 0) begin
               vectors++;
               if (cyc - last_cyc != 3) begin
                  miscompares++;
                  $display("FAIL lat_period: got %0d cycles between instructions, want 3", cyc - last_cyc);
               end
            end
            last_cyc = cyc;
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL lat_drain: %0d left, want 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_wait();
      exp_t e;
      logic seen4;
      lat = 3;
      do_reset();
      seen4 = 1'b0;
      for (int c = 0; c < 20 && !seen4; c++) begin
         tick();
         if (bus.req && bus.addr == 32'h4) seen4 = 1'b1;
      end
      tick();
      rst = 1'b1; inj = 1'b1; inj_data = 32'hDEAD_BEEF;
      tick();
      vectors++;
      if ({pc_d, instr_d, pc_plus4_d, valid_d, bus.req} !== {32'h0, NOP, 32'h0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL rstwait_d: got pc=%h instr=%h pc4=%h v=%b req=%b, want 0/%h/0/0/0", pc_d, instr_d, pc_plus4_d, valid_d, bus.req, NOP);
      end
      rst = 1'b0;
      tick();
      inj = 1'b0;
      vectors++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h0 || valid_d !== 1'b0) begin
         miscompares++;
         $display("FAIL rstwait_req: got req=%b addr=%h v=%b, want 1/00000000/0", bus.req, bus.addr, valid_d);
      end
      push(32'h0); push(32'h4);
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         tick();
         if (is_new) begin
            vectors++;
            e = exp_q.pop_front();
            if ({pc_d, instr_d, pc_plus4_d} !== {e.pc, e.instr, e.pc4}) begin
               miscompares++;
               $display("FAIL rstwait_seq: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h", pc_d, instr_d, pc_plus4_d, e.pc, e.instr, e.pc4);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL rstwait_drain: %0d left, want 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_wrap();
      exp_t e;
      int   nreq;
      lat = 1;
      do_reset();
      br = 1'b1; br_tgt = 32'hFFFF_FFFE;
      tick();
      br = 1'b0;
      vectors++;
      if (bus.req !== 1'b1 || bus.addr !== 32'hFFFF_FFFC) begin
         miscompares++;
         $display("FAIL wrap_req0: got req=%b addr=%h, want 1/fffffffc", bus.req, bus.addr);
      end
      push(32'hFFFF_FFFC); push(32'h0); push(32'h4);
      nreq = 0;
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         tick();
         if (bus.req) begin
            nreq++;
            if (nreq == 1) begin
               vectors++;
               if (bus.addr !== 32'h0) begin
                  miscompares++;
                  $display("FAIL wrap_req1: got addr=%h, want 00000000", bus.addr);
               end
            end
         end
         if (is_new) begin
            vectors++;
            e = exp_q.pop_front();
            if ({pc_d, instr_d, pc_plus4_d} !== {e.pc, e.instr, e.pc4}) begin
               miscompares++;
               $display("FAIL wrap_seq: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h", pc_d, instr_d, pc_plus4_d, e.pc, e.instr, e.pc4);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL wrap_drain: %0d left, want 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect();
      test_flush_stall();
      test_latency();
      test_reset_mid_wait();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
